// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared RV32I pipeline types: register index and the ID/EX stage payload.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef struct packed {
    logic        valid;
    rv32i_reg    rs1;
    rv32i_reg    rs2;
    rv32i_reg    rd;
    logic        load_regfile;
    logic        is_load;
    logic [31:0] pc;
  } id_ex_stage_t;

  // All-zero payload: no valid, no write-enable, so forwarding can never match it.
  localparam id_ex_stage_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_detector.sv
// Combinational load-use hazard check between the instruction in ID/EX and the one in IF/ID.
module load_use_detector
  import rv32i_types::*;
(
  input  logic     if_valid,
  input  rv32i_reg if_rs1,
  input  rv32i_reg if_rs2,
  input  logic     if_uses_rs1,
  input  logic     if_uses_rs2,
  input  logic     ex_valid,
  input  logic     ex_is_load,
  input  rv32i_reg ex_rd,
  output logic     hazard
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = if_uses_rs1 & (if_rs1 == ex_rd);
  assign rs2_hit = if_uses_rs2 & (if_rs2 == ex_rd);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard  = if_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_hazard_stage
  import rv32i_types::*;
#(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_ID_valid_i,
  input  logic [4:0]        IF_ID_rs1_i,
  input  logic [4:0]        IF_ID_rs2_i,
  input  logic [4:0]        IF_ID_rd_i,
  input  logic              IF_ID_uses_rs1_i,
  input  logic              IF_ID_uses_rs2_i,
  input  logic              IF_ID_load_regfile_i,
  input  logic              IF_ID_is_load_i,
  input  logic [31:0]       IF_ID_pc_i,
  input  logic [CTRL_W-1:0] IF_ID_ctrl_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic              perf_clr_i,
  output logic              ID_EX_valid_o,
  output logic [4:0]        ID_EX_rs1_o,
  output logic [4:0]        ID_EX_rs2_o,
  output logic [4:0]        ID_EX_rd_o,
  output logic              ID_EX_load_regfile_o,
  output logic              ID_EX_is_load_o,
  output logic [31:0]       ID_EX_pc_o,
  output logic [CTRL_W-1:0] ID_EX_ctrl_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  id_ex_stage_t      stage_q, stage_cap;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hazard;

  load_use_detector u_det (
    .if_valid    (IF_ID_valid_i),
    .if_rs1      (IF_ID_rs1_i),
    .if_rs2      (IF_ID_rs2_i),
    .if_uses_rs1 (IF_ID_uses_rs1_i),
    .if_uses_rs2 (IF_ID_uses_rs2_i),
    .ex_valid    (stage_q.valid),
    .ex_is_load  (stage_q.is_load),
    .ex_rd       (stage_q.rd),
    .hazard      (hazard)
  );

  assign load_use_stall_o = hazard & ~flush_i;

  always_comb begin
    stage_cap              = ID_EX_BUBBLE;
    stage_cap.valid        = IF_ID_valid_i;
    stage_cap.rs1          = IF_ID_rs1_i;
    stage_cap.rs2          = IF_ID_rs2_i;
    stage_cap.rd           = IF_ID_rd_i;
    stage_cap.load_regfile = IF_ID_valid_i & IF_ID_load_regfile_i;
    stage_cap.is_load      = IF_ID_valid_i & IF_ID_is_load_i;
    stage_cap.pc           = IF_ID_pc_i;
  end

  // Bubbles leave ctrl untouched; it is don't-care whenever valid is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= ID_EX_BUBBLE;
      ctrl_q  <= '0;
    end else if (!mem_stall_i) begin
      if (flush_i || hazard) begin
        stage_q <= ID_EX_BUBBLE;
      end else begin
        stage_q <= stage_cap;
        ctrl_q  <= IF_ID_ctrl_i;
      end
    end
  end

  // Clear wins over a coincident bubble increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!mem_stall_i) begin
      if (perf_clr_i)
        cnt_q <= '0;
      else if (hazard && !flush_i && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ID_EX_valid_o        = stage_q.valid;
  assign ID_EX_rs1_o          = stage_q.rs1;
  assign ID_EX_rs2_o          = stage_q.rs2;
  assign ID_EX_rd_o           = stage_q.rd;
  assign ID_EX_load_regfile_o = stage_q.load_regfile;
  assign ID_EX_is_load_o      = stage_q.is_load;
  assign ID_EX_pc_o           = stage_q.pc;
  assign ID_EX_ctrl_o         = ctrl_q;
  assign bubble_cnt_o         = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed checks for ID/EX register, load-use stall, flush, freeze and bubble counter.
module tb_id_ex_hazard_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              IF_ID_valid_i, IF_ID_uses_rs1_i, IF_ID_uses_rs2_i;
  logic              IF_ID_load_regfile_i, IF_ID_is_load_i;
  logic [4:0]        IF_ID_rs1_i, IF_ID_rs2_i, IF_ID_rd_i;
  logic [31:0]       IF_ID_pc_i;
  logic [CTRL_W-1:0] IF_ID_ctrl_i;
  logic              mem_stall_i, flush_i, perf_clr_i;
  logic              ID_EX_valid_o, ID_EX_load_regfile_o, ID_EX_is_load_o;
  logic [4:0]        ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o;
  logic [31:0]       ID_EX_pc_o;
  logic [CTRL_W-1:0] ID_EX_ctrl_o;
  logic              load_use_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_valid_i(IF_ID_valid_i), .IF_ID_rs1_i(IF_ID_rs1_i), .IF_ID_rs2_i(IF_ID_rs2_i),
    .IF_ID_rd_i(IF_ID_rd_i), .IF_ID_uses_rs1_i(IF_ID_uses_rs1_i),
    .IF_ID_uses_rs2_i(IF_ID_uses_rs2_i), .IF_ID_load_regfile_i(IF_ID_load_regfile_i),
    .IF_ID_is_load_i(IF_ID_is_load_i), .IF_ID_pc_i(IF_ID_pc_i), .IF_ID_ctrl_i(IF_ID_ctrl_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i), .perf_clr_i(perf_clr_i),
    .ID_EX_valid_o(ID_EX_valid_o), .ID_EX_rs1_o(ID_EX_rs1_o), .ID_EX_rs2_o(ID_EX_rs2_o),
    .ID_EX_rd_o(ID_EX_rd_o), .ID_EX_load_regfile_o(ID_EX_load_regfile_o),
    .ID_EX_is_load_o(ID_EX_is_load_o), .ID_EX_pc_o(ID_EX_pc_o), .ID_EX_ctrl_o(ID_EX_ctrl_o),
    .load_use_stall_o(load_use_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic lr, input logic ld, input logic [31:0] pc);
    IF_ID_valid_i = v; IF_ID_rs1_i = rs1; IF_ID_rs2_i = rs2; IF_ID_rd_i = rd;
    IF_ID_uses_rs1_i = u1; IF_ID_uses_rs2_i = u2; IF_ID_load_regfile_i = lr;
    IF_ID_is_load_i = ld; IF_ID_pc_i = pc; IF_ID_ctrl_i = pc[CTRL_W-1:0];
  endtask

  task automatic drive_lw(input logic [4:0] rd, input logic [31:0] pc);
    drive(1'b1, 5'd2, 5'd0, rd, 1'b1, 1'b0, 1'b1, 1'b1, pc);
  endtask

  task automatic drive_add(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] pc);
    drive(1'b1, rs1, rs2, rd, 1'b1, 1'b1, 1'b1, 1'b0, pc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mem_stall_i = 0; flush_i = 0; perf_clr_i = 0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1; tick(); tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive_lw(5'd5, 32'h100); tick();
    drive_add(5'd5, 5'd1, 5'd6, 32'h104); tick();
    drive_add(5'd5, 5'd1, 5'd6, 32'h104); tick();
    drive_lw(5'd9, 32'h108); tick();
    // async reset between edges
    @(negedge clk); rst = 1; #1;
    checks++;
    if ({ID_EX_valid_o, ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o, ID_EX_load_regfile_o,
         ID_EX_is_load_o, ID_EX_pc_o} !== '0) begin
      errors++; $display("FAIL reset_regs: valid=%0b rd=%0d pc=%h want 0", ID_EX_valid_o, ID_EX_rd_o, ID_EX_pc_o);
    end
    checks++;
    if (bubble_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt_o); end
    checks++;
    if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", load_use_stall_o); end
    tick(); rst = 0; #1;
  endtask

  task automatic test_latency();
    do_reset();
    drive_add(5'd3, 5'd4, 5'd7, 32'h200); tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o, ID_EX_load_regfile_o, ID_EX_is_load_o, ID_EX_pc_o, ID_EX_ctrl_o}
        !== {1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 32'h200, 8'h00}) begin
      errors++; $display("FAIL capture: rs1=%0d rs2=%0d rd=%0d pc=%h want 3 4 7 200", ID_EX_rs1_o, ID_EX_rs2_o, ID_EX_rd_o, ID_EX_pc_o);
    end
    // invalid slot must drop write-enable and load flag
    drive(1'b0, 5'd1, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h204); tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_load_regfile_o, ID_EX_is_load_o} !== 3'b000) begin
      errors++; $display("FAIL invalid_capture: v/lr/ld=%b want 000", {ID_EX_valid_o, ID_EX_load_regfile_o, ID_EX_is_load_o});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_lw(5'd5, 32'h300); tick();
    drive_add(5'd5, 5'd1, 5'd6, 32'h304); #1;
    checks++;
    if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", load_use_stall_o); end
    tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_load_regfile_o, bubble_cnt_o} !== {1'b0, 1'b0, 4'd1}) begin
      errors++; $display("FAIL lu_bubble: valid=%0b lr=%0b cnt=%0d want 0 0 1", ID_EX_valid_o, ID_EX_load_regfile_o, bubble_cnt_o);
    end
    checks++;
    if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: stall=%0b want 0", load_use_stall_o); end
    tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_rs1_o, ID_EX_rd_o, bubble_cnt_o} !== {1'b1, 5'd5, 5'd6, 4'd1}) begin
      errors++; $display("FAIL lu_advance: valid=%0b rs1=%0d rd=%0d cnt=%0d want 1 5 6 1", ID_EX_valid_o, ID_EX_rs1_o, ID_EX_rd_o, bubble_cnt_o);
    end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    drive_lw(5'd0, 32'h400); tick();
    drive_add(5'd0, 5'd0, 5'd6, 32'h404); #1;
    checks++;
    if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall: got %0b want 0", load_use_stall_o); end
    drive_lw(5'd7, 32'h408); tick();
    // rs2 matches rd but is not read
    drive(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40c); #1;
    checks++;
    if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL unused_rs2: got %0b want 0", load_use_stall_o); end
    tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_rd_o, bubble_cnt_o} !== {1'b1, 5'd8, 4'd0}) begin
      errors++; $display("FAIL nofalse_adv: valid=%0b rd=%0d cnt=%0d want 1 8 0", ID_EX_valid_o, ID_EX_rd_o, bubble_cnt_o);
    end
    // rs2 dependency does stall
    drive_lw(5'd9, 32'h410); tick();
    drive(1'b1, 5'd3, 5'd9, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h414); #1;
    checks++;
    if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL rs2_stall: got %0b want 1", load_use_stall_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive_lw(5'd5, 32'h500); tick();
    drive_add(5'd1, 5'd5, 5'd6, 32'h504); flush_i = 1; #1;
    checks++;
    if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", load_use_stall_o); end
    tick(); flush_i = 0;
    checks++;
    if ({ID_EX_valid_o, ID_EX_rd_o, ID_EX_load_regfile_o, ID_EX_is_load_o, bubble_cnt_o} !== {1'b0, 5'd0, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL flush_bubble: valid=%0b rd=%0d cnt=%0d want 0 0 0", ID_EX_valid_o, ID_EX_rd_o, bubble_cnt_o);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    drive_lw(5'd5, 32'h600); tick();
    drive_add(5'd5, 5'd1, 5'd6, 32'h604); mem_stall_i = 1;
    repeat (3) tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_rd_o, ID_EX_is_load_o, ID_EX_pc_o, bubble_cnt_o} !== {1'b1, 5'd5, 1'b1, 32'h600, 4'd0}) begin
      errors++; $display("FAIL freeze_hold: valid=%0b rd=%0d pc=%h cnt=%0d want 1 5 600 0", ID_EX_valid_o, ID_EX_rd_o, ID_EX_pc_o, bubble_cnt_o);
    end
    mem_stall_i = 0; tick();
    checks++;
    if ({ID_EX_valid_o, bubble_cnt_o} !== {1'b0, 4'd1}) begin
      errors++; $display("FAIL freeze_release: valid=%0b cnt=%0d want 0 1", ID_EX_valid_o, bubble_cnt_o);
    end
    tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_pc_o, bubble_cnt_o} !== {1'b1, 32'h604, 4'd1}) begin
      errors++; $display("FAIL freeze_advance: valid=%0b pc=%h cnt=%0d want 1 604 1", ID_EX_valid_o, ID_EX_pc_o, bubble_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_lw(5'd5, 32'h700); tick();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h704); tick(); // lw x6,0(x5): bubble
    tick(); // lw x6 advances
    drive(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h708); #1;   // lw x7,0(x6)
    checks++;
    if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %0b want 1", load_use_stall_o); end
    tick(); tick();
    checks++;
    if ({ID_EX_valid_o, ID_EX_rd_o, bubble_cnt_o} !== {1'b1, 5'd7, 4'd2}) begin
      errors++; $display("FAIL b2b_count: valid=%0b rd=%0d cnt=%0d want 1 7 2", ID_EX_valid_o, ID_EX_rd_o, bubble_cnt_o);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_lw(5'd5, 32'h800); tick();
      drive_add(5'd5, 5'd1, 5'd6, 32'h804); tick();
    end
    checks++;
    if (bubble_cnt_o !== 4'd15) begin errors++; $display("FAIL saturate: got %0d want 15", bubble_cnt_o); end
    mem_stall_i = 1; perf_clr_i = 1; tick();
    checks++;
    if (bubble_cnt_o !== 4'd15) begin errors++; $display("FAIL clr_frozen: got %0d want 15", bubble_cnt_o); end
    mem_stall_i = 0; perf_clr_i = 0;
    drive_lw(5'd5, 32'h808); tick();
    drive_add(5'd5, 5'd1, 5'd6, 32'h80c); perf_clr_i = 1; tick(); perf_clr_i = 0;
    checks++;
    if ({ID_EX_valid_o, bubble_cnt_o} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL clr_with_bubble: valid=%0b cnt=%0d want 0 0", ID_EX_valid_o, bubble_cnt_o);
    end
  endtask

  initial begin
    rst = 1; mem_stall_i = 0; flush_i = 0; perf_clr_i = 0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_latency();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_freeze();
    test_back_to_back();
    test_saturate_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
